// File: rtl/mem_pkg.sv
// Shared types and RV32I load/store funct3 encodings for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational sub-word store merge, load extract/extend and access legality check.
module mem_align_unit
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        write_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        wword_o = rword_i;
        rdata_o = '0;
        err_o   = 1'b0;
        unique case (funct3_i)
            F3_B, F3_BU: begin
                wword_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
                rdata_o = {{24{(funct3_i == F3_B) & byte_sel[7]}}, byte_sel};
                err_o   = write_i && (funct3_i == F3_BU);
            end
            F3_H, F3_HU: begin
                wword_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                rdata_o = {{16{(funct3_i == F3_H) & half_sel[15]}}, half_sel};
                err_o   = addr_lo_i[0] || (write_i && (funct3_i == F3_HU));
            end
            F3_W: begin
                wword_o = wdata_i;
                rdata_o = rword_i;
                err_o   = (addr_lo_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Word-organised RAM responder with wait states and sub-word load/store handling.
// Optional MEM_STATS_EN adds saturating load/store/error counters.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, wdata_q;
    logic           write_q;
    logic [2:0]     funct3_q;
    logic [31:0]    rword_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  rd_idx;
    logic [31:0]    wword, ld_val;
    logic           acc_err;
    logic           accept;

    assign accept    = (state_q == IDLE) && req_valid;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CW'(WAIT_CYCLES - 1)) state_d = ACCESS;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= req_addr;
                write_q  <= req_write;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (state_q == ACCESS) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || write_q) ? 32'h0 : ld_val;
            end
        end
    end

    // Read address follows the incoming request while idle so the old word is
    // already registered on entry to ACCESS, even with zero wait states.
    assign rd_idx = (state_q == IDLE) ? req_addr[2 +: AW] : addr_q[2 +: AW];

    always_ff @(posedge clk) begin
        if (state_q == ACCESS && write_q && !acc_err)
            mem[addr_q[2 +: AW]] <= wword;
        rword_q <= mem[rd_idx];
    end

    mem_align_unit u_align (
        .funct3_i  (funct3_q),
        .write_i   (write_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (rword_q),
        .wword_o   (wword),
        .rdata_o   (ld_val),
        .err_o     (acc_err)
    );

`ifdef MEM_STATS_EN
    logic [15:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (state_q == ACCESS) begin
            if (acc_err) begin
                if (errs_q != 16'hFFFF) errs_q <= errs_q + 1'b1;
            end else if (write_q) begin
                if (stores_q != 16'hFFFF) stores_q <= stores_q + 1'b1;
            end else begin
                if (loads_q != 16'hFFFF) loads_q <= loads_q + 1'b1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for data paths/errors/reset and a
// WAIT_CYCLES=0 instance for back-to-back issue and address aliasing.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Instance A: default wait states
    logic        rst_a, vld_a, wr_a, rdy_a, rv_a, err_a;
    logic [31:0] addr_a, wd_a, rd_a;
    logic [2:0]  f3_a;
    // Instance B: zero wait states
    logic        rst_b, vld_b, wr_b, rdy_b, rv_b, err_b;
    logic [31:0] addr_b, wd_b, rd_b;
    logic [2:0]  f3_b;
`ifdef MEM_STATS_EN
    logic [15:0] sl_a, ss_a, se_a, sl_b, ss_b, se_b;
`endif

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(rst_a), .req_valid(vld_a), .req_ready(rdy_a),
        .req_addr(addr_a), .req_write(wr_a), .req_funct3(f3_a), .req_wdata(wd_a),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
`ifdef MEM_STATS_EN
        , .stat_loads(sl_a), .stat_stores(ss_a), .stat_errs(se_a)
`endif
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst_b), .req_valid(vld_b), .req_ready(rdy_b),
        .req_addr(addr_b), .req_write(wr_b), .req_funct3(f3_b), .req_wdata(wd_b),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
`ifdef MEM_STATS_EN
        , .stat_loads(sl_b), .stat_stores(ss_b), .stat_errs(se_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
        $display("check %-14s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic req_a(input string tag, input logic [31:0] a, input logic w,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        lat = 0;
        @(negedge clk);
        vld_a = 1'b1; addr_a = a; wr_a = w; f3_a = f3; wd_a = wd;
        @(posedge clk); #1;
        vld_a = 1'b0; addr_a = 32'hx; wd_a = 32'hx;
        chk({tag, ".busy"}, {31'b0, rdy_a}, 32'd0);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            if (i > 1 || !rv_a) begin
                @(posedge clk); #1;
            end
            if (rv_a) lat = i;
        end
        chk({tag, ".lat"}, lat, 32'd3);
        chk({tag, ".rd"}, rd_a, exp_rd);
        chk({tag, ".err"}, {31'b0, err_a}, {31'b0, exp_err});
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {31'b0, rv_a}, 32'd0);
    endtask

    task automatic req_b(input string tag, input logic [31:0] a, input logic w,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        int lat;
        lat = 0;
        @(negedge clk);
        vld_b = 1'b1; addr_b = a; wr_b = w; f3_b = f3; wd_b = wd;
        @(posedge clk); #1;
        vld_b = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (rv_b) lat = i;
        end
        chk({tag, ".lat"}, lat, 32'd1);
        chk({tag, ".rd"}, rd_b, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen, pulses, last;
        rst_a = 1'b0; vld_a = 1'b0; wr_a = 1'b0; f3_a = '0; addr_a = '0; wd_a = '0;
        rst_b = 1'b0; vld_b = 1'b0; wr_b = 1'b0; f3_b = '0; addr_b = '0; wd_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'b0, rdy_a}, 32'd1);
        chk("rst.valid", {31'b0, rv_a}, 32'd0);
        chk("rst.rdata", rd_a, 32'd0);
        chk("rst.err", {31'b0, err_a}, 32'd0);
        @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;

        req_a("sw10",  32'h10, 1'b1, F3_W,  32'hDEADBEEF, 32'h0,        1'b0);
        req_a("lw10",  32'h10, 1'b0, F3_W,  32'h0,        32'hDEADBEEF, 1'b0);
        req_a("sb13",  32'h13, 1'b1, F3_B,  32'h000000AA, 32'h0,        1'b0);
        req_a("lw10b", 32'h10, 1'b0, F3_W,  32'h0,        32'hAAADBEEF, 1'b0);
        req_a("lbu13", 32'h13, 1'b0, F3_BU, 32'h0,        32'h000000AA, 1'b0);
        req_a("lb13",  32'h13, 1'b0, F3_B,  32'h0,        32'hFFFFFFAA, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold.rd", rd_a, 32'hFFFFFFAA);
        req_a("lb11",  32'h11, 1'b0, F3_B,  32'h0,        32'hFFFFFFBE, 1'b0);

        req_a("sw20",  32'h20, 1'b1, F3_W,  32'h11223344, 32'h0,        1'b0);
        req_a("sh22",  32'h22, 1'b1, F3_H,  32'h00008001, 32'h0,        1'b0);
        req_a("lh22",  32'h22, 1'b0, F3_H,  32'h0,        32'hFFFF8001, 1'b0);
        req_a("lhu22", 32'h22, 1'b0, F3_HU, 32'h0,        32'h00008001, 1'b0);
        req_a("lw20",  32'h20, 1'b0, F3_W,  32'h0,        32'h80013344, 1'b0);

        req_a("lw11e", 32'h11, 1'b0, F3_W,  32'h0,        32'h0,        1'b1);
        req_a("sh23e", 32'h23, 1'b1, F3_H,  32'h0000FFFF, 32'h0,        1'b1);
        req_a("ld011", 32'h20, 1'b0, 3'b011, 32'h0,       32'h0,        1'b1);
        req_a("st100", 32'h20, 1'b1, F3_BU, 32'hFFFFFFFF, 32'h0,        1'b1);
        req_a("lw20c", 32'h20, 1'b0, F3_W,  32'h0,        32'h80013344, 1'b0);
        req_a("lw10c", 32'h10, 1'b0, F3_W,  32'h0,        32'hAAADBEEF, 1'b0);

        // Reset while the store to 0x30 is in WAIT must drop it entirely.
        req_a("sw30",  32'h30, 1'b1, F3_W,  32'h0BADF00D, 32'h0,        1'b0);
        @(negedge clk);
        vld_a = 1'b1; addr_a = 32'h30; wr_a = 1'b1; f3_a = F3_W; wd_a = 32'h12345678;
        @(posedge clk); #1;
        vld_a = 1'b0;
        @(negedge clk); rst_a = 1'b0;
        #1;
        chk("mid.ready", {31'b0, rdy_a}, 32'd1);
        chk("mid.valid", {31'b0, rv_a}, 32'd0);
        @(negedge clk); rst_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rv_a) seen++;
        end
        chk("mid.nopulse", seen, 32'd0);
        req_a("lw30",  32'h30, 1'b0, F3_W,  32'h0,        32'h0BADF00D, 1'b0);

        // Zero-wait instance: alias store, then continuously held loads.
        req_b("b.sw",  32'h10 + 32'd4096, 1'b1, F3_W, 32'hCAFEF00D, 32'h0);
        req_b("b.lw",  32'h10, 1'b0, F3_W, 32'h0, 32'hCAFEF00D);
        @(negedge clk);
        vld_b = 1'b1; addr_b = 32'h10; wr_b = 1'b0; f3_b = F3_W;
        pulses = 0; last = -1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (rv_b) begin
                pulses++;
                chk("b.stream.rd", rd_b, 32'hCAFEF00D);
                if (last >= 0) chk("b.interval", e - last, 32'd3);
                last = e;
            end
        end
        @(negedge clk); vld_b = 1'b0;
        chk("b.pulses", pulses, 32'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
